display_slot_ctrl: RTL and testbench

//  Sequences writes into the 8-digit seven-segment decoder. Accepts one decoded Morse character per

---
 rtl/morse_disp_pkg.sv | 22 ++
 rtl/slot_shadow_buf.sv | 44 ++++
 rtl/display_slot_ctrl.sv | 113 +++++++++++
 tb/tb_display_slot_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/morse_disp_pkg.sv
// Shared constants and types for the Morse display slot controller.
package morse_disp_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int CHAR_W    = 6;
    localparam int IDX_W     = $clog2(NUM_SLOTS);

    localparam logic [CHAR_W-1:0] BLANK_CODE = CHAR_W'(6'h3F);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_SLOTS - 1);
    localparam logic [IDX_W:0]    FULL_COUNT = (IDX_W + 1)'(NUM_SLOTS);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR, SCROLL} state_t;

    typedef enum logic [2:0] {
        BUF_NOP,
        BUF_WRITE,
        BUF_SHIFT,
        BUF_CLEAR,
        BUF_CLEAR_WRITE
    } buf_op_t;

endpackage

// File: rtl/slot_shadow_buf.sv
// Shadow register file holding the code currently shown in each display slot.
// Supports write-at-index, shift-down-with-insert, clear-all and an async read port.
module slot_shadow_buf
    import morse_disp_pkg::*;
(
    input  logic              clk_100Mhz,
    input  logic              reset,
    input  buf_op_t           op,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [CHAR_W-1:0] rd_data
);

    logic [CHAR_W-1:0] slots [NUM_SLOTS];

    // NOTE: this small register file is reset on purpose so the shadow
    // always agrees with the blanked display; it is flops, not a RAM.
    always_ff @(posedge clk_100Mhz or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_SLOTS; k++) slots[k] <= BLANK_CODE;
        end else begin
            case (op)
                BUF_WRITE: slots[wr_idx] <= wr_data;
                BUF_SHIFT: begin
                    for (int k = 0; k < NUM_SLOTS - 1; k++) slots[k] <= slots[k+1];
                    slots[NUM_SLOTS-1] <= wr_data;
                end
                BUF_CLEAR: begin
                    for (int k = 0; k < NUM_SLOTS; k++) slots[k] <= BLANK_CODE;
                end
                BUF_CLEAR_WRITE: begin
                    // The later assignment to wr_idx overrides the blanking.
                    for (int k = 0; k < NUM_SLOTS; k++) slots[k] <= BLANK_CODE;
                    slots[wr_idx] <= wr_data;
                end
                default: ;
            endcase
        end
    end

    assign rd_data = slots[rd_idx];

endmodule

// File: rtl/display_slot_ctrl.sv
// Sequences decoder writes for received Morse characters: fill, then scroll or wrap.
// Define DISP_SCROLL_EN for scrolling on a full display; default build wraps to slot 0.
module display_slot_ctrl
    import morse_disp_pkg::*;
(
    input  logic              clk_100Mhz,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [CHAR_W-1:0] rx_char,
    output logic              rx_ready,
    input  logic              clr,
    output logic              data_valid,
    output logic [IDX_W-1:0]  char_index,
    output logic [CHAR_W-1:0] char_data,
    output logic              busy,
    output logic [IDX_W:0]    fill_count
);

    state_t            state;
    logic [IDX_W-1:0]  slot_cnt;
    buf_op_t           buf_op;
    logic [IDX_W-1:0]  buf_idx;
    logic [CHAR_W-1:0] shadow_rd;
    logic              full;

    assign full     = (fill_count == FULL_COUNT);
    assign rx_ready = (state == IDLE) && !clr;
    assign busy     = (state == CLEAR) || (state == SCROLL);

    always_comb begin
        buf_op  = BUF_NOP;
        buf_idx = fill_count[IDX_W-1:0];
        if (state == IDLE) begin
            if (clr) begin
                buf_op = BUF_CLEAR;
            end else if (rx_valid) begin
                if (!full) begin
                    buf_op = BUF_WRITE;
                end else begin
`ifdef DISP_SCROLL_EN
                    buf_op = BUF_SHIFT;
`else
                    buf_op  = BUF_CLEAR_WRITE;
                    buf_idx = '0;
`endif
                end
            end
        end
    end

    slot_shadow_buf u_shadow (
        .clk_100Mhz (clk_100Mhz),
        .reset      (reset),
        .op         (buf_op),
        .wr_idx     (buf_idx),
        .wr_data    (rx_char),
        .rd_idx     (slot_cnt),
        .rd_data    (shadow_rd)
    );

    // NOTE: all state and decoder outputs use non-blocking assignments so every
    // branch sees the pre-edge values of state, slot_cnt and fill_count.
    always_ff @(posedge clk_100Mhz or negedge reset) begin
        if (!reset) begin
            state      <= CLEAR;
            slot_cnt   <= '0;
            fill_count <= '0;
            data_valid <= 1'b0;
            char_index <= '0;
            char_data  <= '0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr) begin
                        state    <= CLEAR;
                        slot_cnt <= '0;
                    end else if (rx_valid) begin
                        if (!full) begin
                            state      <= WRITE;
                            data_valid <= 1'b1;
                            char_index <= fill_count[IDX_W-1:0];
                            char_data  <= rx_char;
                            fill_count <= fill_count + 1'b1;
                        end else begin
                            state    <= SCROLL;
                            slot_cnt <= '0;
`ifdef DISP_SCROLL_EN
                            fill_count <= FULL_COUNT;
`else
                            fill_count <= (IDX_W + 1)'(1);
`endif
                        end
                    end
                end
                WRITE: state <= IDLE;
                CLEAR, SCROLL: begin
                    // The shadow already holds the updated contents, so SCROLL just replays it.
                    data_valid <= 1'b1;
                    char_index <= slot_cnt;
                    char_data  <= (state == CLEAR) ? BLANK_CODE : shadow_rd;
                    slot_cnt   <= slot_cnt + 1'b1;
                    if (slot_cnt == LAST_IDX) begin
                        state <= IDLE;
                        if (state == CLEAR) fill_count <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_slot_ctrl.sv
// Self-checking bench for display_slot_ctrl: directed steps plus random characters
// checked against a slot-level model of what the display should show.
module tb_display_slot_ctrl;

    localparam int SLOTS = 8;
    localparam int BLANK = 'h3F;

    logic       tb_clk_100Mhz = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [5:0] rx_char;
    logic       rx_ready;
    logic       clr;
    logic       data_valid;
    logic [2:0] char_index;
    logic [5:0] char_data;
    logic       busy;
    logic [3:0] fill_count;

    int total = 0;
    int bad   = 0;

    int ref_disp [SLOTS];
    int ref_fill;
    int exp_q [$];
    int obs_q [$];
    int ready_while_busy;

    always #5 tb_clk_100Mhz = ~tb_clk_100Mhz;

    display_slot_ctrl dut (
        .clk_100Mhz (tb_clk_100Mhz),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_char    (rx_char),
        .rx_ready   (rx_ready),
        .clr        (clr),
        .data_valid (data_valid),
        .char_index (char_index),
        .char_data  (char_data),
        .busy       (busy),
        .fill_count (fill_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected display after a blanking: every slot unlit, eight blank writes in order.
    task automatic model_clear();
        for (int k = 0; k < SLOTS; k++) begin
            ref_disp[k] = BLANK;
            exp_q.push_back(k * 256 + BLANK);
        end
        ref_fill = 0;
    endtask

    task automatic model_accept(input int c);
        if (ref_fill < SLOTS) begin
            ref_disp[ref_fill] = c;
            exp_q.push_back(ref_fill * 256 + c);
            ref_fill++;
        end else begin
`ifdef DISP_SCROLL_EN
            for (int k = 0; k < SLOTS - 1; k++) ref_disp[k] = ref_disp[k+1];
            ref_disp[SLOTS-1] = c;
`else
            for (int k = 0; k < SLOTS; k++) ref_disp[k] = BLANK;
            ref_disp[0] = c;
            ref_fill = 1;
`endif
            for (int k = 0; k < SLOTS; k++) exp_q.push_back(k * 256 + ref_disp[k]);
        end
    endtask

    // One clock: sample outputs on the falling edge and log any decoder write.
    task automatic cycle();
        @(negedge tb_clk_100Mhz);
        if (data_valid === 1'b1) obs_q.push_back(int'(char_index) * 256 + int'(char_data));
        if (busy === 1'b1 && rx_ready === 1'b1) ready_while_busy++;
    endtask

    task automatic send(input logic [5:0] c);
        int  n;
        int  pre;
        bit  took;
        n    = 0;
        pre  = 0;
        took = 1'b0;
        rx_valid = 1'b1;
        rx_char  = c;
        while (!took && n < 60) begin
            #1;
            took = (rx_ready === 1'b1);
            if (took) begin
                pre = ref_fill;
                model_accept(int'(c));
            end
            cycle();
            n++;
        end
        rx_valid = 1'b0;
        check($sformatf("accept_%02h", c), 32'(took), 32'd1);
        if (took && pre < SLOTS) begin
            check($sformatf("wr_strobe_%02h", c), 32'(data_valid), 32'd1);
            check($sformatf("wr_index_%02h", c), 32'(char_index), 32'(pre));
            check($sformatf("wr_data_%02h", c), 32'(char_data), 32'(c));
        end
    endtask

    // Let pending writes finish, then compare the write log and settled status.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 60) begin
            cycle();
            n++;
        end
        cycle();
        cycle();
        check({tag, "_wr_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_fill"}, 32'(fill_count), 32'(ref_fill));
        check({tag, "_ready_busy"}, 32'(ready_while_busy), 32'd0);
        #1;
        check({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
        obs_q.delete();
        exp_q.delete();
        ready_while_busy = 0;
    endtask

    initial begin
        rx_valid = 1'b0;
        rx_char  = '0;
        clr      = 1'b0;
        reset    = 1'b1;
        ready_while_busy = 0;
        #2 reset = 1'b0;

        // Step 1: reset state, then the power-on blanking sequence.
        cycle();
        cycle();
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_index", 32'(char_index), 32'd0);
        check("rst_data", 32'(char_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_ready", 32'(rx_ready), 32'd0);
        check("rst_fill", 32'(fill_count), 32'd0);
        obs_q.delete();
        reset = 1'b1;
        model_clear();
        cycle();
        check("clr_first_busy", 32'(busy), 32'd1);
        check("clr_first_valid", 32'(data_valid), 32'd1);
        drain("power_on_clear");

        // Step 2: three characters, each written one cycle after its transfer.
        send(6'h01);
        send(6'h02);
        send(6'h03);
        drain("first_three");

        // Step 3: fill the display, then overflow by one.
        for (int c = 4; c <= 8; c++) send(6'(c));
        drain("fill_to_full");
        send(6'h09);
        drain("overflow");

        // Random characters, crossing the full boundary several times.
        for (int i = 0; i < 14; i++) begin
            send(6'($urandom_range(0, 62)));
            drain($sformatf("rand%0d", i));
        end

        // Step 4: clr beats a simultaneous rx_valid; the char goes in afterwards.
        clr      = 1'b1;
        rx_valid = 1'b1;
        rx_char  = 6'h05;
        #1;
        check("clr_vs_rx_ready", 32'(rx_ready), 32'd0);
        cycle();
        clr = 1'b0;
        model_clear();
        send(6'h05);
        drain("clr_then_05");

        // Step 5: reset on the 4th SCROLL cycle aborts, then a full CLEAR follows.
        while (ref_fill < SLOTS) begin
            send(6'($urandom_range(0, 62)));
            drain("refill");
        end
        send(6'h2A);
        cycle();
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        check("abort_valid", 32'(data_valid), 32'd0);
        check("abort_fill", 32'(fill_count), 32'd0);
        check("abort_busy", 32'(busy), 32'd1);
        cycle();
        cycle();
        check("abort_hold_valid", 32'(data_valid), 32'd0);
        obs_q.delete();
        exp_q.delete();
        ready_while_busy = 0;
        reset = 1'b1;
        model_clear();
        drain("post_abort_clear");

        // Step 6: a second clr in the middle of CLEAR is ignored.
        send(6'h11);
        send(6'h22);
        drain("pre_clr");
        clr = 1'b1;
        model_clear();
        cycle();
        clr = 1'b0;
        cycle();
        cycle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        drain("clr_mid_clear");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
